// File: rtl/paillier_pkg.sv
// paillier_pkg: shared Paillier core types and default engine dimensions
package paillier_pkg;
    localparam int MM_K = 128;
    localparam int MM_N = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_FEED, ST_DRAIN} mm_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int R = 3,
    parameter int PW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  gnt,
    output logic [PW-1:0] idx
);
    logic          found;
    logic [PW-1:0] j;
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = 0; k < R; k++) begin
            j = PW'((int'(ptr) + k) % R);
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/paillier_mm_arbiter.sv
// paillier_mm_arbiter: shares one Montgomery engine among R requesters with a stall watchdog
module paillier_mm_arbiter
    import paillier_pkg::*;
#(
    parameter int K = MM_K,
    parameter int N = MM_N,
    parameter int R = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req,
    input  logic [R*K-1:0] req_x,
    input  logic [R*K-1:0] req_y,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   gnt,
    output logic           busy,
    output logic [K-1:0]   rsp_data,
    output logic [R-1:0]   rsp_valid,
    output logic [R-1:0]   done,
    output logic [R-1:0]   err,
    output logic           mm_start,
    output logic [K-1:0]   mm_x,
    output logic [K-1:0]   mm_y,
    output logic           mm_x_valid,
    output logic           mm_y_valid,
    input  logic [K-1:0]   mm_result,
    input  logic           mm_valid
);
    localparam int PW = $clog2(R);
    localparam int NW = $clog2(N + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    mm_arb_state_t state;
    logic [PW-1:0] g_idx, ptr, arb_idx, nxt;
    logic [R-1:0]  arb_gnt;
    logic [NW-1:0] in_cnt, out_cnt;
    logic [WW-1:0] wd;
    logic          accept;

    rr_arbiter #(.R(R), .PW(PW)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    assign busy   = state != ST_IDLE;
    assign accept = (state == ST_FEED) && |(req_valid & gnt);
    assign nxt    = (g_idx == PW'(R - 1)) ? '0 : g_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            g_idx      <= '0;
            ptr        <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            wd         <= '0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            done       <= '0;
            err        <= '0;
            mm_start   <= 1'b0;
            mm_x       <= '0;
            mm_y       <= '0;
            mm_x_valid <= 1'b0;
            mm_y_valid <= 1'b0;
        end else begin
            mm_start   <= 1'b0;
            mm_x_valid <= 1'b0;
            mm_y_valid <= 1'b0;
            rsp_valid  <= '0;
            done       <= '0;
            err        <= '0;
            case (state)
                ST_IDLE: if (|req) begin
                    gnt      <= arb_gnt;
                    g_idx    <= arb_idx;
                    mm_start <= 1'b1;
                    state    <= ST_START;
                end
                ST_START: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    wd      <= '0;
                    state   <= ST_FEED;
                end
                default: if (out_cnt == NW'(N)) begin
                    // done was pulsed last cycle; release one cycle later
                    gnt   <= '0;
                    ptr   <= nxt;
                    state <= ST_IDLE;
                end else begin
                    if (accept) begin
                        mm_x       <= req_x[g_idx*K +: K];
                        mm_y       <= req_y[g_idx*K +: K];
                        mm_x_valid <= 1'b1;
                        mm_y_valid <= 1'b1;
                        in_cnt     <= in_cnt + NW'(1);
                        if (in_cnt == NW'(N - 1)) state <= ST_DRAIN;
                    end
                    if (mm_valid) begin
                        rsp_data  <= mm_result;
                        rsp_valid <= gnt;
                        out_cnt   <= out_cnt + NW'(1);
                        if (out_cnt == NW'(N - 1)) done <= gnt;
                    end
                    if (accept || mm_valid) wd <= '0;
                    else if (wd == WW'(TIMEOUT - 1)) begin
                        err   <= gnt;
                        gnt   <= '0;
                        ptr   <= nxt;
                        state <= ST_IDLE;
                    end else wd <= wd + WW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_paillier_mm_arbiter.sv
// tb_paillier_mm_arbiter: table, directed and random checks against an engine model and arbitration model
module tb_paillier_mm_arbiter;
    localparam int R = 3, N = 4, K = 8, TIMEOUT = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [R-1:0]   req = '0, req_valid = '0;
    logic [R*K-1:0] req_x = '0, req_y = '0;
    logic [R-1:0]   gnt, rsp_valid, done, err;
    logic           busy, mm_start, mm_x_valid, mm_y_valid, mm_valid;
    logic [K-1:0]   rsp_data, mm_x, mm_y, mm_result;
    logic           eng_valid = 1'b0, inj_valid = 1'b0;
    logic [K-1:0]   eng_result = '0, inj_result = '0;
    int checks = 0, errors = 0, cyc = 0, ptr_m = 0, last_done = -100;
    logic [K-1:0]   wx[N], wy[N], wexp[N];

    typedef struct packed {logic [K-1:0] x, y, p;} vec_t;

    paillier_mm_arbiter #(.K(K), .N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .req_valid(req_valid), .gnt(gnt), .busy(busy), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .done(done), .err(err), .mm_start(mm_start),
        .mm_x(mm_x), .mm_y(mm_y), .mm_x_valid(mm_x_valid), .mm_y_valid(mm_y_valid),
        .mm_result(mm_result), .mm_valid(mm_valid)
    );

    assign mm_valid  = eng_valid | inj_valid;
    assign mm_result = inj_valid ? inj_result : eng_result;

    always #5 clk = ~clk;

    // engine model: collects products, replays them 8 cycles after the Nth operand
    logic [K-1:0] eq[$];
    int nin = 0, tmr = 0;
    bit emit = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq.delete(); nin = 0; tmr = 0; emit = 1'b0; eng_valid = 1'b0; eng_result = '0;
        end else begin
            eng_valid = 1'b0;
            if (mm_start) begin eq.delete(); nin = 0; tmr = 0; emit = 1'b0; end
            if (mm_x_valid) begin
                eq.push_back(K'((int'(mm_x) * int'(mm_y)) % 251));
                nin++;
                if (nin == N) tmr = 8;
            end else if (tmr > 0) begin
                tmr--;
                if (tmr == 0) emit = 1'b1;
            end
            if (emit) begin
                if (eq.size() > 0) begin eng_valid = 1'b1; eng_result = eq.pop_front(); end
                else emit = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [R-1:0] pick(input logic [R-1:0] m, input int p);
        for (int k = 0; k < R; k++)
            if (m[(p + k) % R]) return R'(1) << ((p + k) % R);
        return '0;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            wx[i] = K'($urandom_range(0, 255));
            wy[i] = K'($urandom_range(0, 255));
            wexp[i] = K'((int'(wx[i]) * int'(wy[i])) % 251);
        end
    endtask

    task automatic serve(input int nw, input bit foreign, input bit exp_err,
                         input logic [R-1:0] req_after, input logic [R-1:0] exp_g, input bit chk_gap);
        int n = 0, gi = 0, fi, beats = 0;
        logic [R-1:0] g;
        while (gnt == '0 && n < 10) begin tick(); n++; end
        chk("grant", 64'(gnt), 64'(exp_g));
        if (gnt == '0) return;
        g = gnt;
        for (int i = 0; i < R; i++) if (g[i]) gi = i;
        fi = (gi + 1) % R;
        chk("mm_start", 64'(mm_start), 64'(1));
        chk("busy_on", 64'(busy), 64'(1));
        if (chk_gap) chk("rr_gap", 64'(cyc - last_done), 64'(2));
        req_valid = '0;
        req_valid[gi] = 1'b1;
        tick();
        req_valid = '0;
        chk("start_strobe_ignored", 64'(mm_x_valid), 64'(0));
        for (int w = 0; w < nw; w++) begin
            if (foreign) begin
                req_x[fi*K +: K] = wx[w] + K'(1);
                req_y[fi*K +: K] = wy[w] + K'(1);
                req_valid = '0;
                req_valid[fi] = 1'b1;
                tick();
                chk("foreign_ignored", 64'(mm_x_valid), 64'(0));
            end
            req_x[gi*K +: K] = wx[w];
            req_y[gi*K +: K] = wy[w];
            req_valid = '0;
            req_valid[gi] = 1'b1;
            if (foreign) req_valid[fi] = 1'b1;
            tick();
            req_valid = '0;
            chk("x_valid", 64'({mm_x_valid, mm_y_valid}), 64'(2'b11));
            chk("x_word", 64'({mm_x, mm_y}), 64'({wx[w], wy[w]}));
        end
        if (exp_err) begin
            n = 0;
            while (err == '0 && n < 24) begin tick(); n++; end
            chk("err_delay", 64'(n), 64'(16));
            chk("err_who", 64'(err), 64'(g));
            chk("err_idle", 64'({busy, gnt}), 64'(0));
            req = req_after;
        end else begin
            n = 0;
            while (beats < N && n < 40) begin
                tick(); n++;
                if (rsp_valid != '0) begin
                    chk("rsp_valid", 64'(rsp_valid), 64'(g));
                    chk("rsp_data", 64'(rsp_data), 64'(wexp[beats]));
                    beats++;
                    chk("done", 64'(done), (beats == N) ? 64'(g) : 64'(0));
                    chk("err_quiet", 64'(err), 64'(0));
                end else if (done != '0) chk("done_stray", 64'(done), 64'(0));
            end
            chk("beats", 64'(beats), 64'(N));
            last_done = cyc;
            req = req_after;
            tick();
            chk("busy_off", 64'(busy), 64'(0));
            chk("gnt_off", 64'(gnt), 64'(0));
        end
        ptr_m = (gi + 1) % R;
    endtask

    initial begin
        vec_t tbl[N];
        logic [R-1:0] rr_exp[4];
        logic [R-1:0] m;
        int n;
        tbl[0] = '{x: 8'd3, y: 8'd5,  p: 8'd15};
        tbl[1] = '{x: 8'd7, y: 8'd11, p: 8'd77};
        tbl[2] = '{x: 8'd2, y: 8'd2,  p: 8'd4};
        tbl[3] = '{x: 8'd9, y: 8'd9,  p: 8'd81};
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        tick(); tick();
        chk("reset_outs", 64'({gnt, busy, rsp_data, rsp_valid, done, err, mm_start,
                               mm_x, mm_y, mm_x_valid, mm_y_valid}), 64'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) begin wx[i] = tbl[i].x; wy[i] = tbl[i].y; wexp[i] = tbl[i].p; end
        req = 3'b001;
        serve(N, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0);

        inj_valid = 1'b1; inj_result = 8'hAA;
        tick();
        inj_valid = 1'b0;
        chk("stray_rsp", 64'(rsp_valid), 64'(0));
        chk("stray_busy", 64'(busy), 64'(0));
        tick();
        chk("stray_state", 64'({busy, gnt}), 64'(0));

        rst_n = 1'b0; tick(); rst_n = 1'b1; ptr_m = 0; tick();
        req = 3'b111;
        for (int op = 0; op < 4; op++) begin
            fill_rand();
            serve(N, 1'b0, 1'b0, (op == 3) ? 3'b000 : 3'b111, rr_exp[op], op > 0);
        end

        fill_rand();
        req = 3'b001;
        serve(N, 1'b1, 1'b0, 3'b000, pick(req, ptr_m), 1'b0);

        fill_rand();
        req = 3'b001;
        serve(2, 1'b0, 1'b1, 3'b011, pick(req, ptr_m), 1'b0);
        fill_rand();
        serve(N, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0);

        fill_rand();
        req = 3'b100;
        n = 0;
        while (gnt == '0 && n < 10) begin tick(); n++; end
        chk("mid_gnt", 64'(gnt), 64'(3'b100));
        tick();
        for (int w = 0; w < N; w++) begin
            req_x[2*K +: K] = wx[w]; req_y[2*K +: K] = wy[w]; req_valid = 3'b100;
            tick();
        end
        req_valid = '0;
        tick(); tick();
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", 64'({gnt, busy, rsp_data, rsp_valid, done, err, mm_start,
                                   mm_x, mm_y, mm_x_valid, mm_y_valid}), 64'(0));
        tick(); tick();
        rst_n = 1'b1; ptr_m = 0; req = 3'b110;
        fill_rand();
        serve(N, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            m = R'($urandom_range(1, 7));
            req = m;
            serve(N, r[0], 1'b0, 3'b000, pick(m, ptr_m), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/paillier_mm_arbiter.md
# paillier_mm_arbiter

Round-robin arbiter and sequencer that shares one Montgomery-multiplication engine (`mm_iddmm_top`) among R requesters inside the Paillier core: encryption, decryption L-step and homomorphic add. It grants the engine to one requester at a time and issues the engine start pulse. It forwards that requester's N-word operand stream to the engine, routes the N result words back, and signals completion. A watchdog recovers from stalled feeds or a silent engine.

## Interface
Parameters:
- K, 128, word width in bits
- N, 32, words per operand/result
- R, 3, number of requesters (≥2)
- TIMEOUT, 4096, max idle cycles in FEED/DRAIN before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  R  per-requester operation request; held high until done/err
- req_x  in  R*K  operand x words; requester i occupies bits [i*K +: K]
- req_y  in  R*K  operand y words; same packing as req_x
- req_valid  in  R  word strobe per requester
- gnt  out  R  one-hot grant, registered
- busy  out  1  high in any state other than IDLE
- rsp_data  out  K  result word, shared by all requesters
- rsp_valid  out  R  one-hot result strobe
- done  out  R  one-cycle pulse on the last result word
- err  out  R  one-cycle pulse on watchdog abort
- mm_start  out  1  engine start pulse
- mm_x  out  K  engine x operand
- mm_y  out  K  engine y operand
- mm_x_valid  out  1  engine x strobe
- mm_y_valid  out  1  engine y strobe
- mm_result  in  K  engine result word
- mm_valid  in  1  engine result strobe

## Operation
- States: IDLE, START, FEED, DRAIN.
- **IDLE:** if any `req` bit is high, select the first set bit at or after `ptr`, wrapping modulo R. Latch the one-hot grant `g`. Go to START. `ptr` resets to 0.
- **START:** `mm_start` is 1 for this state only. Clear `in_cnt`, `out_cnt` and the watchdog. Go to FEED.
- **FEED:** each cycle with `req_valid & g` nonzero registers the granted slice to `mm_x`/`mm_y` with both valids 1, and increments `in_cnt`. On the Nth word, go to DRAIN. Strobes from non-granted requesters are ignored. Strobes arriving in IDLE or START are ignored.
- **Result counting (FEED and DRAIN):** each `mm_valid` produces `rsp_data <= mm_result` and `rsp_valid <= g`, and increments `out_cnt`.
- **Completion:** when `out_cnt` reaches N, pulse `done <= g` in the same cycle as the last `rsp_valid`. Then clear `gnt`, set `ptr` to the index after the granted requester (mod R), and return to IDLE.
- **Early results:** results arriving during FEED are forwarded and counted. If N results arrive before all N operand words, still complete.
- **Deasserted request:** if `req[g]` drops mid-operation, the operation still runs to completion. The engine cannot be aborted.
- **Watchdog:** counts cycles with no accepted word (FEED) or no result (DRAIN), and resets on each accepted word or result. When it reaches TIMEOUT: pulse `err <= g`, clear `gnt`, advance `ptr`, go to IDLE.
- **Stray results:** `mm_valid` in IDLE or START is discarded; no `rsp_valid` is raised.
- **Counter widths:** `in_cnt` and `out_cnt` are $clog2(N+1) bits. The watchdog is $clog2(TIMEOUT+1) bits.

## Timing
- **Reset values:** `gnt`, `busy`, `rsp_data`, `rsp_valid`, `done`, `err`, `mm_start`, `mm_x`, `mm_y`, `mm_x_valid` and `mm_y_valid` are all 0. State is IDLE.
- **Grant latency:** `req` sampled at cycle t gives `gnt` and `busy` at t+1, with `mm_start` high at t+1. FEED begins at t+2.
- **Operand path:** `req_valid` at cycle c gives `mm_x_valid` at c+1. There is no backpressure, so the requester may stream one word per cycle from t+2.
- **Result path:** `mm_valid` at cycle c gives `rsp_valid` at c+1.
- **Back-to-back grants:** `done` at cycle d means IDLE at d+1. The next grant is at d+2 at the earliest.
- **Mid-operation reset:** all outputs return to reset values immediately and asynchronously. The engine shares `rst_n`.
- **Simultaneous watchdog expiry and Nth result:** `done` wins and `err` is not pulsed.

## Structure
- **Shared package `paillier_pkg`:** state enum `mm_arb_state_t` and the default K/N constants, shared with `paillier_top`.
- **Sub-module `rr_arbiter`:** R-bit request vector plus pointer in, one-hot grant out; purely combinational. The FSM owns the registered `gnt` and `ptr`.

## Test plan
Bench configuration: R=3, N=4, K=8, TIMEOUT=16, with an engine model returning x*y mod 251 eight cycles after the last word.
- **Single request:** `req`=001, then 4 words (x,y) = (3,5),(7,11),(2,2),(9,9). Expect 4 `rsp_valid[0]` beats with data 15,77,4,81. `done[0]` coincides with the 4th beat. `busy` falls the next cycle.
- **Round-robin:** `req`=111 held throughout. Expect grant order 001, 010, 100, 001, with each `done` preceding the next `gnt` by 2 cycles.
- **Foreign strobes:** requester 1 strobes words while requester 0 is granted. Expect `mm_x_valid` only for requester 0's words and `in_cnt` to reach exactly 4.
- **Stalled feed:** the granted requester stops after 2 words. Expect `err[0]` exactly 16 cycles after the last word, then IDLE, then the grant passes to requester 1.
- **Mid-operation reset:** assert `rst_n`=0 during DRAIN. Expect all outputs 0 immediately. After release, a new request completes normally with `ptr`=0.
- **Stray result:** inject `mm_valid` in IDLE. Expect no `rsp_valid` and no state change.
